// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with stall, flush-to-bubble, Tuse/Tnew countdown
//   clk, clr (sync active-high reset), en (advance), flush (insert bubble), valid_in
//   pc_in/ins_in, opnd_in (N_OPND packed DATA_W channels), imm_in, rs/rt/rd_in, tuse/tnew_in
//   *_out registered copies; wr_pending = valid_out & rd_out!=0 & tnew_out!=0
//   Optional macro PIPE_STAGE_PERF_EN adds stall_cnt/flush_cnt performance counters.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int N_OPND = 2,
  parameter int T_W = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic flush,
  input  logic valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] ins_in,
  input  logic [N_OPND*DATA_W-1:0] opnd_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [4:0] rs_in,
  input  logic [4:0] rt_in,
  input  logic [4:0] rd_in,
  input  logic [T_W-1:0] tuse_in,
  input  logic [T_W-1:0] tnew_in,
  output logic [31:0] pc_out,
  output logic [31:0] ins_out,
  output logic [N_OPND*DATA_W-1:0] opnd_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [4:0] rs_out,
  output logic [4:0] rt_out,
  output logic [4:0] rd_out,
  output logic [T_W-1:0] tuse_out,
  output logic [T_W-1:0] tnew_out,
  output logic valid_out,
  output logic wr_pending
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  // initializers give the reset values from time zero
  logic [31:0] pc_q = RESET_PC;
  logic [31:0] ins_q = '0;
  logic [N_OPND*DATA_W-1:0] opnd_q = '0;
  logic [DATA_W-1:0] imm_q = '0;
  logic [4:0] rs_q = '0;
  logic [4:0] rt_q = '0;
  logic [4:0] rd_q = '0;
  logic [T_W-1:0] tuse_q = '0;
  logic [T_W-1:0] tnew_q = '0;
  logic valid_q = 1'b0;
  // saturating countdown: one stage closer, never below zero
  function automatic logic [T_W-1:0] dec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q <= RESET_PC;
      ins_q <= '0;
      opnd_q <= '0;
      imm_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      rd_q <= '0;
      tuse_q <= '0;
      tnew_q <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      // bubble keeps the squashed address
      pc_q <= pc_in;
      ins_q <= '0;
      opnd_q <= '0;
      imm_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      rd_q <= '0;
      tuse_q <= '0;
      tnew_q <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      pc_q <= pc_in;
      ins_q <= ins_in;
      opnd_q <= opnd_in;
      imm_q <= imm_in;
      rs_q <= rs_in;
      rt_q <= rt_in;
      rd_q <= valid_in ? rd_in : 5'd0;
      tuse_q <= valid_in ? dec(tuse_in) : '0;
      tnew_q <= valid_in ? dec(tnew_in) : '0;
      valid_q <= valid_in;
    end
  end
  assign pc_out = pc_q;
  assign ins_out = ins_q;
  assign opnd_out = opnd_q;
  assign imm_out = imm_q;
  assign rs_out = rs_q;
  assign rt_out = rt_q;
  assign rd_out = rd_q;
  assign tuse_out = tuse_q;
  assign tnew_out = tnew_q;
  assign valid_out = valid_q;
  assign wr_pending = valid_q && (rd_q != 5'd0) && (tnew_q != '0);
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_q = '0;
  logic [31:0] flush_q = '0;
  always_ff @(posedge clk) begin
    if (clr) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (flush) flush_q <= flush_q + 32'd1;
    else if (!en && valid_q) stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vector table plus randomized run against a reference model
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  logic clr = 1'b0, en = 1'b0, flush = 1'b0, valid_in = 1'b0;
  logic [31:0] pc_in = '0, ins_in = '0;
  logic [63:0] opnd_in = '0;
  logic [31:0] imm_in = '0;
  logic [4:0] rs_in = '0, rt_in = '0, rd_in = '0;
  logic [1:0] tuse_in = '0, tnew_in = '0;
  logic [31:0] pc_out, ins_out, imm_out;
  logic [63:0] opnd_out;
  logic [4:0] rs_out, rt_out, rd_out;
  logic [1:0] tuse_out, tnew_out;
  logic valid_out, wr_pending;
  int total = 0, bad = 0;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  pipe_stage_reg dut (
    .clk(clk), .clr(clr), .en(en), .flush(flush), .valid_in(valid_in),
    .pc_in(pc_in), .ins_in(ins_in), .opnd_in(opnd_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .tuse_in(tuse_in), .tnew_in(tnew_in),
    .pc_out(pc_out), .ins_out(ins_out), .opnd_out(opnd_out), .imm_out(imm_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .tuse_out(tuse_out),
    .tnew_out(tnew_out), .valid_out(valid_out), .wr_pending(wr_pending)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic clr, flush, en, valid;
    logic [31:0] pc, ins, op1;
    logic [4:0] rd;
    logic [1:0] tnew, tuse;
    logic [31:0] e_pc, e_ins, e_op1;
    logic [4:0] e_rd;
    logic [1:0] e_tnew, e_tuse;
    logic e_v, e_wp;
  } vec_t;
  vec_t tbl [9];
  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask
  logic [31:0] m_pc, m_ins, m_imm, m_sc, m_fc;
  logic [63:0] m_op;
  logic [4:0] m_rs, m_rt, m_rd;
  logic [1:0] m_tu, m_tn;
  logic m_v;
  initial begin
    tbl[0] = '{1,0,1,1, 32'h3333, 32'hAAAA, 32'h5555, 5'd4, 2'd3, 2'd3, 32'h3000, 32'h0, 32'h0, 5'd0, 2'd0, 2'd0, 0, 0};
    tbl[1] = '{0,0,1,1, 32'h3004, 32'h12345678, 32'h11111111, 5'd5, 2'd2, 2'd2, 32'h3004, 32'h12345678, 32'h11111111, 5'd5, 2'd1, 2'd1, 1, 1};
    tbl[2] = '{0,0,0,1, 32'h3100, 32'hABCD0001, 32'h22222222, 5'd9, 2'd3, 2'd3, 32'h3004, 32'h12345678, 32'h11111111, 5'd5, 2'd1, 2'd1, 1, 1};
    tbl[3] = '{0,0,0,0, 32'h3104, 32'hABCD0002, 32'h22222223, 5'd10, 2'd0, 2'd1, 32'h3004, 32'h12345678, 32'h11111111, 5'd5, 2'd1, 2'd1, 1, 1};
    tbl[4] = '{0,0,0,1, 32'h3108, 32'hABCD0003, 32'h22222224, 5'd0, 2'd3, 2'd0, 32'h3004, 32'h12345678, 32'h11111111, 5'd5, 2'd1, 2'd1, 1, 1};
    tbl[5] = '{0,1,0,1, 32'h3010, 32'hFFFFFFFF, 32'h44444444, 5'd3, 2'd2, 2'd2, 32'h3010, 32'h0, 32'h0, 5'd0, 2'd0, 2'd0, 0, 0};
    tbl[6] = '{0,0,1,1, 32'h3020, 32'h1, 32'h33333333, 5'd6, 2'd0, 2'd0, 32'h3020, 32'h1, 32'h33333333, 5'd6, 2'd0, 2'd0, 1, 0};
    tbl[7] = '{0,0,1,0, 32'h3024, 32'h2, 32'hDEADBEEF, 5'd7, 2'd2, 2'd2, 32'h3024, 32'h2, 32'hDEADBEEF, 5'd0, 2'd0, 2'd0, 0, 0};
    tbl[8] = '{1,1,1,1, 32'h3028, 32'h3, 32'h5, 5'd8, 2'd3, 2'd3, 32'h3000, 32'h0, 32'h0, 5'd0, 2'd0, 2'd0, 0, 0};
    #1;
    chk("powerup", {pc_out, ins_out, opnd_out, imm_out, rs_out, rt_out, rd_out, tuse_out, tnew_out, valid_out, wr_pending},
        {32'h3000, 149'd0});
    for (int i = 0; i < 9; i++) begin
      clr = tbl[i].clr; flush = tbl[i].flush; en = tbl[i].en; valid_in = tbl[i].valid;
      pc_in = tbl[i].pc; ins_in = tbl[i].ins; opnd_in = {tbl[i].op1, 32'h0};
      rd_in = tbl[i].rd; tnew_in = tbl[i].tnew; tuse_in = tbl[i].tuse;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), {pc_out, ins_out, opnd_out[63:32], rd_out, tnew_out, tuse_out, valid_out, wr_pending},
          {tbl[i].e_pc, tbl[i].e_ins, tbl[i].e_op1, tbl[i].e_rd, tbl[i].e_tnew, tbl[i].e_tuse, tbl[i].e_v, tbl[i].e_wp});
`ifdef PIPE_STAGE_PERF_EN
      if (i == 4) chk("stall_cnt3", stall_cnt, 32'd3);
      if (i == 5) chk("flush_cnt1", {stall_cnt, flush_cnt}, {32'd3, 32'd1});
      if (i == 8) chk("cnt_clr", {stall_cnt, flush_cnt}, 64'd0);
`endif
    end
    for (int c = 0; c < 400; c++) begin
      clr = (c == 0) || ($urandom_range(31) == 0);
      flush = ($urandom_range(7) == 0);
      en = ($urandom_range(3) != 0);
      valid_in = ($urandom_range(3) != 0);
      pc_in = $urandom; ins_in = $urandom; opnd_in = {$urandom, $urandom}; imm_in = $urandom;
      rs_in = 5'($urandom); rt_in = 5'($urandom);
      rd_in = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
      tuse_in = 2'($urandom); tnew_in = 2'($urandom);
      if (clr) begin
        m_sc = 0; m_fc = 0;
      end else if (flush) m_fc = m_fc + 1;
      else if (!en && m_v) m_sc = m_sc + 1;
      if (clr || flush) begin
        m_pc = clr ? 32'h3000 : pc_in;
        m_ins = 0; m_op = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_tu = 0; m_tn = 0; m_v = 0;
      end else if (en) begin
        m_pc = pc_in; m_ins = ins_in; m_op = opnd_in; m_imm = imm_in; m_rs = rs_in; m_rt = rt_in;
        m_v = valid_in;
        m_rd = valid_in ? rd_in : 5'd0;
        m_tu = (valid_in && tuse_in > 0) ? tuse_in - 2'd1 : 2'd0;
        m_tn = (valid_in && tnew_in > 0) ? tnew_in - 2'd1 : 2'd0;
      end
      @(posedge clk); #1;
      chk($sformatf("rand%0d", c),
          {pc_out, ins_out, opnd_out, imm_out, rs_out, rt_out, rd_out, tuse_out, tnew_out, valid_out, wr_pending},
          {m_pc, m_ins, m_op, m_imm, m_rs, m_rt, m_rd, m_tu, m_tn, m_v, (m_v && m_rd != 0 && m_tn != 0)});
`ifdef PIPE_STAGE_PERF_EN
      chk($sformatf("rcnt%0d", c), {stall_cnt, flush_cnt}, {m_sc, m_fc});
`endif
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/immediate channel width.
REQ-002 SHALL have parameter N_OPND, default 2, meaning number of operand channels carried.
REQ-003 SHALL have parameter T_W, default 2, meaning Tuse/Tnew field width.
REQ-004 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning pc_out value after clr.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-006 SHALL have port clr  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port en  input  1  advance enable; 0 = stall/hold.
REQ-008 SHALL have port flush  input  1  insert bubble this cycle.
REQ-009 SHALL have port valid_in  input  1  incoming slot holds a real instruction.
REQ-010 SHALL have ports pc_in and ins_in  input  32 each  instruction address and word.
REQ-011 SHALL have port opnd_in  input  N_OPND*DATA_W  packed operands, channel k at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port imm_in  input  DATA_W  extended immediate.
REQ-013 SHALL have ports rs_in, rt_in, rd_in  input  5 each  register indices; rd_in is the write destination.
REQ-014 SHALL have ports tuse_in and tnew_in  input  T_W each  stage counts relative to the upstream stage.
REQ-015 SHALL have outputs pc_out, ins_out, opnd_out, imm_out, rs_out, rt_out, rd_out, tuse_out, tnew_out, with widths matching their inputs, each driven directly from its register.
REQ-016 SHALL have output valid_out  1  registered slot-valid flag.
REQ-017 SHALL have output wr_pending  1  combinational: valid_out AND rd_out!=0 AND tnew_out!=0.

Function
REQ-018 SHALL apply per-cycle priority clr > flush > (en==0) > load.
REQ-019 SHALL, on load (en=1, flush=0, clr=0), capture every input in one cycle, with outputs visible the cycle after the edge (latency 1).
REQ-020 SHALL, on load, set tnew_out = tnew_in-1 if tnew_in>0, else 0; tuse_out follows the same rule (saturating, no wrap).
REQ-021 SHALL, on load with valid_in=0, force rd_out=0, tnew_out=0 and tuse_out=0, and set valid_out=0; all other fields load normally.
REQ-022 SHALL, on flush, set valid_out=0, ins_out=0, opnd_out=0, imm_out=0, rs/rt/rd_out=0 and tuse/tnew_out=0, while pc_out <= pc_in, so the bubble carries the squashed address.
REQ-023 SHALL, on stall (en=0, flush=0), hold every register unchanged, including tnew_out and tuse_out (no countdown while held).
REQ-024 SHALL treat flush together with en=0 as a flush.
REQ-025 SHALL let wr_pending deassert in the same cycle that tnew_out becomes 0 or valid_out falls.

Reset
REQ-026 SHALL, on clr=1 at posedge clk, set pc_out=RESET_PC and all other outputs to 0, including valid_out; en and flush are ignored.
REQ-027 SHALL hold the same reset values from time zero (power-up initial state).
REQ-028 SHALL, when clr is asserted mid-stall, discard the held instruction and take effect on the same edge.

Configuration
REQ-029 SHALL, with macro PIPE_STAGE_PERF_EN defined, add outputs stall_cnt[31:0] and flush_cnt[31:0].
REQ-030 SHALL increment stall_cnt on each edge with clr=0, flush=0, en=0 AND valid_out=1.
REQ-031 SHALL increment flush_cnt on each edge with clr=0 and flush=1.
REQ-032 SHALL wrap both counters modulo 2^32 and clear both on clr.
REQ-033 SHALL, without PIPE_STAGE_PERF_EN, omit both ports and counters, leaving behaviour otherwise identical.

Verification
REQ-034 SHALL cover load: clr then en=1, valid_in=1, pc_in=0x3004, rd_in=5, tnew_in=2 -> next cycle pc_out=0x3004, rd_out=5, tnew_out=1, valid_out=1, wr_pending=1.
REQ-035 SHALL cover saturation: tnew_in=0, tuse_in=0 loaded -> tnew_out=0, tuse_out=0 (no wrap to 3), wr_pending=0.
REQ-036 SHALL cover stall: after the load in REQ-034, en=0 for 3 cycles with changing inputs -> all outputs constant, tnew_out stays 1; stall_cnt=3 when PIPE_STAGE_PERF_EN is defined.
REQ-037 SHALL cover flush priority: flush=1, en=0, pc_in=0x3010, ins_in=0xFFFFFFFF -> pc_out=0x3010, ins_out=0, rd_out=0, valid_out=0; flush_cnt increments by 1.
REQ-038 SHALL cover reset over flush: clr=1 and flush=1 together -> pc_out=0x00003000, every other output 0, both counters 0.
REQ-039 SHALL cover invalid load: valid_in=0, rd_in=7, tnew_in=2, opnd_in channel1=0xDEADBEEF -> rd_out=0, tnew_out=0, valid_out=0, opnd_out channel1=0xDEADBEEF.
